// File: rtl/dot_product_stream.sv
// Streaming dot-product accumulator: reduces LANES x EW operand pairs per beat into a burst-wide sum.
// Latency: the result is registered and presented the cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a result is held; out_ready releases it, then one idle cycle follows.
module dot_product_stream #(
    parameter int LANES = 4,
    parameter int EW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*EW-1:0]   in_a,
    input  logic [LANES*EW-1:0]   in_b,
    input  logic                  in_last,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_result,
    output logic [15:0]           out_beats,
    output logic                  out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         mode_q;
    logic [1:0]         mode_eff;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   partial;
    logic [ACC_W-1:0]   acc_sum;
    logic               carry;
    logic               signed_ovf;
    logic [15:0]        beats;
    logic               ovf;
    logic               accept;
    logic [EW-1:0]      lane_a;
    logic [EW-1:0]      lane_b;
    logic [ACC_W-1:0]   ext_a;
    logic [ACC_W-1:0]   ext_b;

    // The first beat of a burst uses the live mode; later beats use the latched one.
    assign mode_eff = (state == IDLE) ? mode : mode_q;
    assign in_ready = !reset && (state != DONE);
    assign accept   = in_valid && in_ready;

    assign out_valid  = (state == DONE);
    assign out_result = acc;
    assign out_beats  = beats;
    assign out_ovf    = ovf;

    // Per-beat partial. Lanes are extended to ACC_W before multiplying, so the
    // modular product already carries the correct sign extension in signed mode.
    always_comb begin
        partial = '0;
        lane_a  = '0;
        lane_b  = '0;
        ext_a   = '0;
        ext_b   = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_a = in_a[k*EW +: EW];
            lane_b = in_b[k*EW +: EW];
            if (mode_eff == 2'b00) begin
                for (int j = 0; j < EW; j++) begin
                    partial = partial + ACC_W'(lane_a[j] & lane_b[j]);
                end
            end else if (mode_eff == 2'b10) begin
                ext_a   = {{(ACC_W-EW){lane_a[EW-1]}}, lane_a};
                ext_b   = {{(ACC_W-EW){lane_b[EW-1]}}, lane_b};
                partial = partial + ext_a * ext_b;
            end else begin
                ext_a   = {{(ACC_W-EW){1'b0}}, lane_a};
                ext_b   = {{(ACC_W-EW){1'b0}}, lane_b};
                partial = partial + ext_a * ext_b;
            end
        end
    end

    // Accumulate with carry-out for unsigned overflow and sign comparison for signed overflow.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc} + {1'b0, partial};
        signed_ovf = (acc[ACC_W-1] == partial[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    end

    // Next-state logic: a burst closes on its last beat; a held result leaves on out_ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (accept) state_nxt = in_last ? DONE : ACCUM;
            DONE:        if (out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // State register plus accumulator, beat counter, sticky overflow and mode latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            beats  <= '0;
            ovf    <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= partial;
                        beats  <= 16'd1;
                        ovf    <= 1'b0;
                        mode_q <= mode;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_sum;
                        beats <= (beats == 16'hFFFF) ? beats : beats + 16'd1;
                        ovf   <= ovf | ((mode_q == 2'b10) ? signed_ovf : carry);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        beats <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// Bench for dot_product_stream: a 32-bit and a 20-bit accumulator instance share one stimulus stream.
// A burst-level arithmetic model pushes expected results; monitors pop them on each result handshake.
module tb_dot_product_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  mode;

    logic        in_ready32, out_valid32, out_ovf32;
    logic [31:0] out_result32;
    logic [15:0] out_beats32;
    logic        in_ready20, out_valid20, out_ovf20;
    logic [19:0] out_result20;
    logic [15:0] out_beats20;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [15:0] beats;
        logic        ovf;
    } exp_t;

    exp_t q32[$];
    exp_t q20[$];

    bit         mopen;
    logic [1:0] mmode;
    longint     macc[2];
    int         mbeats[2];
    bit         movf[2];
    bit         rand_rdy;

    always #5 clk = ~clk;

    dot_product_stream dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid32), .out_ready(out_ready), .out_result(out_result32),
        .out_beats(out_beats32), .out_ovf(out_ovf32)
    );

    dot_product_stream #(.ACC_W(20)) dut20 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready20),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid20), .out_ready(out_ready), .out_result(out_result20),
        .out_beats(out_beats20), .out_ovf(out_ovf20)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plain arithmetic value of one beat in the given mode (mode 3 behaves as unsigned).
    function automatic longint beat_value(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            longint x = longint'(a[k*8 +: 8]);
            longint y = longint'(b[k*8 +: 8]);
            if (m == 2'b00) begin
                for (int j = 0; j < 8; j++) s += longint'(a[k*8+j] & b[k*8+j]);
            end else if (m == 2'b10) begin
                if (x > 127) x -= 256;
                if (y > 127) y -= 256;
                s += x * y;
            end else begin
                s += x * y;
            end
        end
        return s;
    endfunction

    // Burst model: running sum kept in range of each accumulator width, overflow when it leaves that range.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input logic last, input logic [1:0] m);
        longint p, v, md, hi;
        exp_t   e;
        if (!mopen) begin
            mopen = 1;
            mmode = m;
            for (int i = 0; i < 2; i++) begin
                macc[i] = 0; mbeats[i] = 0; movf[i] = 0;
            end
        end
        p = beat_value(a, b, mmode);
        for (int i = 0; i < 2; i++) begin
            md = longint'(1) << ((i == 0) ? 32 : 20);
            hi = md / 2;
            v  = macc[i] + p;
            if (mmode == 2'b10) begin
                if (v >= hi || v < -hi) movf[i] = 1;
                v = ((v % md) + md) % md;
                if (v >= hi) v -= md;
            end else begin
                if (v >= md) movf[i] = 1;
                v = v % md;
            end
            macc[i] = v;
            if (mbeats[i] < 65535) mbeats[i]++;
            if (last) begin
                e.res   = 32'(v & (md - 1));
                e.beats = 16'(mbeats[i]);
                e.ovf   = movf[i];
                if (i == 0) q32.push_back(e);
                else        q20.push_back(e);
            end
        end
        if (last) mopen = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Holds a beat on the input until it is accepted; reports the stall cycles.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                        input logic [1:0] m, output int stalls);
        bit done = 0;
        stalls   = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last; mode = m;
        while (!done) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready32) begin
                model_accept(a, b, last, m);
                done = 1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    check("accept_timeout", 64'(stalls), 64'd50);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid32"}, 64'(out_valid32), 64'd0);
        check({tag, "_result32"}, 64'(out_result32), 64'd0);
        check({tag, "_beats32"}, 64'(out_beats32), 64'd0);
        check({tag, "_ovf32"}, 64'(out_ovf32), 64'd0);
        check({tag, "_valid20"}, 64'(out_valid20), 64'd0);
        check({tag, "_result20"}, 64'(out_result20), 64'd0);
    endtask

    // Result monitors: compare on every completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid32 && out_ready) begin
            if (q32.size() == 0) begin
                check("unexpected_result32", 64'(out_result32), 64'd0);
            end else begin
                e = q32.pop_front();
                check("result32", 64'(out_result32), 64'(e.res));
                check("beats32", 64'(out_beats32), 64'(e.beats));
                check("ovf32", 64'(out_ovf32), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid20 && out_ready) begin
            if (q20.size() == 0) begin
                check("unexpected_result20", 64'(out_result20), 64'd0);
            end else begin
                e = q20.pop_front();
                check("result20", 64'(out_result20), 64'(e.res));
                check("beats20", 64'(out_beats20), 64'(e.beats));
                check("ovf20", 64'(out_ovf20), 64'(e.ovf));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [31:0] a, b;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; mode = 2'b00; rand_rdy = 0; mopen = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready32", 64'(in_ready32), 64'd0);
        check("rst_in_ready20", 64'(in_ready20), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("rst");
        check("post_rst_in_ready", 64'(in_ready32), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Binary single-beat burst
        send(32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 2'b00, st);
        idle(2);

        // Unsigned two-beat burst, then the same with a mode change on beat 2
        send(32'h0403_0201, 32'h0101_0101, 1'b0, 2'b01, st);
        send(32'h0403_0201, 32'h0101_0101, 1'b1, 2'b01, st);
        send(32'h0403_0201, 32'h0101_0101, 1'b0, 2'b01, st);
        send(32'h0403_0201, 32'h0101_0101, 1'b1, 2'b00, st);

        // Signed bursts
        send(32'hFF02_0000, 32'h0305_0000, 1'b1, 2'b10, st);
        send(32'hFF00_0000, 32'h0500_0000, 1'b1, 2'b10, st);
        idle(2);

        // Backpressure: result held for three cycles, next beat waits one bubble
        out_ready = 1'b0;
        send(32'h0403_0201, 32'h0101_0101, 1'b1, 2'b01, st);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid32), 64'd1);
            check("bp_result", 64'(out_result32), 64'(q32[0].res));
            check("bp_in_ready", 64'(in_ready32), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h0101_0101, 32'h0202_0202, 1'b1, 2'b01, st);
        check("bp_stall_cycles", 64'(st), 64'd1);

        // Overflow of the 20-bit accumulator over five all-ones beats, then a clean burst
        for (int i = 0; i < 5; i++) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(i == 4), 2'b01, st);
        send(32'h0000_0003, 32'h0000_0004, 1'b1, 2'b01, st);
        idle(2);

        // Reset abandons an open burst
        send(32'h1020_3040, 32'h0102_0304, 1'b0, 2'b01, st);
        send(32'h1020_3040, 32'h0102_0304, 1'b0, 2'b01, st);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mopen = 0;
        @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk); #1;
        send(32'h0000_0205, 32'h0000_0307, 1'b1, 2'b01, st);
        idle(2);

        // Randomized bursts with random downstream readiness
        rand_rdy = 1;
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8080_8080;
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h7F7F_7F7F;
            send(a, b, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), st);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        send(32'h0102_0304, 32'h0506_0708, 1'b1, 2'b10, st);
        rand_rdy = 0;
        out_ready = 1'b1;
        idle(5);

        check("drained32", 64'(q32.size()), 64'd0);
        check("drained20", 64'(q20.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_product_stream.md
# dot_product_stream

Streaming, parametrised dot-product accumulator: the multi-cycle successor to our single-word 1-bit dot-product unit. Each beat accepts two packed vectors of `LANES` elements of `EW` bits, reduces them to one partial product-sum in the selected mode, and adds it into a running accumulator. A burst ends on the `in_last` beat; the block then presents the result, beat count and overflow flag on a registered valid/ready output port. It sits between an operand-fetch stage and a result writeback stage.

## Interface
- `LANES`, 4: elements per beat (≥1).
- `EW`, 8: element width in bits (≥1).
- `ACC_W`, 32: accumulator/result width. Constraint: `ACC_W ≥ 2*EW + clog2(LANES)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_a`  in  LANES*EW  packed vector A; lane k = bits [k*EW+EW-1 : k*EW].
- `in_b`  in  LANES*EW  packed vector B, same packing.
- `in_last`  in  1  final beat of the burst.
- `mode`  in  2  00 = binary (popcount of A&B over all bits); 01 = unsigned multiply; 10 = signed two's-complement multiply; 11 = treated as 01.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  ACC_W  accumulated dot product, two's complement in mode 10.
- `out_beats`  out  16  beats accepted in the burst, saturating at 16'hFFFF.
- `out_ovf`  out  1  sticky flag: the accumulator overflowed at least once in this burst.

## Operation
- States: IDLE (no burst open), ACCUM (burst open), DONE (result held).
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE, forced to 0 while `reset` = 1. A beat is accepted when `in_valid & in_ready`.
- Per-beat partial:
  - mode 00: count of set bits in `in_a & in_b`.
  - mode 01: Σ a_k·b_k, unsigned.
  - mode 10: Σ a_k·b_k, signed, sign-extended to `ACC_W`.
  - The partial is zero-extended (00/01) or sign-extended (10) to `ACC_W`.
- IDLE + accepted beat:
  - `acc` ← partial; `beats` ← 1; `ovf` ← 0.
  - Latch `mode` for the whole burst.
  - Go to ACCUM, or to DONE if `in_last` = 1.
- ACCUM + accepted beat:
  - `acc` ← `acc` + partial, modulo 2^ACC_W.
  - `beats` ← `beats` + 1, saturating.
  - `ovf` \|= carry-out (modes 00/01) or signed overflow (mode 10).
  - Go to DONE if `in_last` = 1.
  - A `mode` input that differs from the latched value mid-burst is ignored.
- DONE:
  - `out_valid` = 1.
  - `out_result`, `out_beats` and `out_ovf` are held stable.
  - When `out_ready` = 1: go to IDLE; accumulator, count and flag are cleared.
- `out_valid` = 0 in IDLE and ACCUM. Outputs are registered; there is no combinational path from inputs to outputs except `in_ready`, which is driven from state.

## Timing
- Reset values: state = IDLE, `out_valid` = 0, `out_result` = 0, `out_beats` = 0, `out_ovf` = 0, `in_ready` = 0 while `reset` is high and 1 on the first cycle after.
- Throughput: one beat per cycle while the burst is open.
- Latency: a `last` beat accepted at edge N gives `out_valid` = 1 after edge N; the result is visible in cycle N+1.
- Result handshake completes at the edge where `out_valid & out_ready`. `in_ready` rises in the following cycle, so at least one bubble separates bursts.
- `out_ready` held high: DONE lasts exactly one cycle.
- `in_valid` while in DONE: not accepted; the upstream holds the beat.
- Reset mid-burst or in DONE: abandons the burst. All outputs return to reset values at the next edge, and no result is emitted.
- Single-beat burst (IDLE + `last`): valid result with `out_beats` = 1.

## Test plan
- Binary, default params: `mode`=00, `in_a`=32'hFFFF_FFFF, `in_b`=32'h0F0F_0F0F, last=1 -> next cycle `out_valid`=1, `out_result`=16, `out_beats`=1, `out_ovf`=0.
- Unsigned two-beat burst: `mode`=01, lanes A={4,3,2,1}, B={1,1,1,1}, sent twice with last on beat 2 -> `out_result`=20, `out_beats`=2. Change `mode` to 00 on beat 2 -> result is still 20.
- Signed: `mode`=10, A lanes = {8'hFF, 8'h02, 0, 0}, B lanes = {8'h03, 8'h05, 0, 0}, last -> `out_result`=32'h0000_0007 (−3+10). Repeat with A={8'hFF, 0, 0, 0}, B={8'h05, 0, 0, 0} -> 32'hFFFF_FFFB.
- Backpressure: hold `out_ready`=0 for 3 cycles after the result -> `out_valid`, `out_result` and `in_ready`=0 are stable. The next beat, held on `in_valid`, is accepted only one cycle after `out_ready` goes high.
- Overflow, instance `ACC_W`=20: `mode`=01, five beats of all-FF on both inputs -> `out_result`=251924 (1300500 mod 2^20), `out_ovf`=1, `out_beats`=5. The next burst starts with `out_ovf`=0.
- Reset after 2 beats of a 3-beat burst -> no `out_valid`, outputs zero. A following 1-beat burst returns only its own partial.
